b11_symbol_feeder: RTL and testbench

//  Upstream pacing stage for the b11 scrambler core. Buffers 6-bit symbols from a

---
 rtl/b11_symbol_feeder.sv | 114 +++++++++++
 tb/tb_b11_symbol_feeder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/b11_symbol_feeder.sv
// b11 symbol feeder: buffers 6-bit symbols in a small FIFO and paces commits to b11.
// state  | meaning
// IDLE   | waiting for a queued symbol with hold released
// STROBE | stbi low for this one cycle, x_in carries the committed symbol
// GAP    | stbi high, gap down-counter enforcing SPACING before the next commit
module b11_symbol_feeder #(
    parameter int DEPTH   = 4,
    parameter int SPACING = 16,
    parameter int CW      = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   hold,
    output logic [5:0]             x_in,
    output logic                   stbi,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] gap;
    logic [CW-1:0] gap_next;
    logic [5:0]    x_next;
    logic          stbi_next;
    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Readiness looks only at the registered level, so a full FIFO refuses even on a pop cycle.
    assign din_ready = (level != LW'(DEPTH));
    assign push      = din_valid & din_ready;
    assign busy      = (level != '0) || (state != IDLE);

    always_comb begin
        state_next = state;
        gap_next   = gap;
        x_next     = x_in;
        stbi_next  = 1'b1;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if ((level != '0) && !hold) begin
                    state_next = STROBE;
                    x_next     = mem[rd_ptr];
                    stbi_next  = 1'b0;
                    pop        = 1'b1;
                end
            end
            STROBE: begin
                state_next = GAP;
                gap_next   = CW'(SPACING);
            end
            GAP: begin
                if (gap == CW'(1)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap - 1'b1;
                end
            end
            default: begin
                state_next = GAP;
                gap_next   = CW'(SPACING);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= GAP;
            gap    <= CW'(SPACING);
            x_in   <= '0;
            stbi   <= 1'b1;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            gap   <= gap_next;
            x_in  <= x_next;
            stbi  <= stbi_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

// File: tb/tb_b11_symbol_feeder.sv
// Bench for b11_symbol_feeder: directed scenarios plus random traffic against a
// timeline model (symbol queue + earliest-allowed-commit cycle).
module tb_b11_symbol_feeder;
    localparam int DEPTH   = 4;
    localparam int SPACING = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       hold;
    logic [5:0] x_in;
    logic       stbi;
    logic [2:0] level;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [5:0] q[$];
    logic [5:0] mx;
    logic       ms;
    int         n = 0;
    int         earliest = 0;
    bit         inited = 0;
    int         pulses[$];

    b11_symbol_feeder #(.DEPTH(DEPTH), .SPACING(SPACING), .CW(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .hold      (hold),
        .x_in      (x_in),
        .stbi      (stbi),
        .level     (level),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare after the edge.
    task automatic cycle(input bit v, input logic [5:0] d, input bit h, input bit r);
        bit ready;
        bit commit;
        bit idle;
        din_valid = v;
        din       = d;
        hold      = h;
        reset     = r;
        #1;
        ready = (q.size() != DEPTH);
        if (inited) check("din_ready", {31'b0, din_ready}, {31'b0, ready});
        if (r) begin
            q.delete();
            mx       = 6'h00;
            ms       = 1'b1;
            earliest = n + SPACING + 1;
            inited   = 1;
        end else begin
            commit = (q.size() != 0) && !h && (n >= earliest);
            ms = 1'b1;
            if (commit) begin
                mx       = q.pop_front();
                ms       = 1'b0;
                earliest = n + SPACING + 2;
            end
            if (v && ready) q.push_back(d);
        end
        @(posedge clock);
        #1;
        idle = (n + 1 >= earliest);
        check("x_in",  {26'b0, x_in},  {26'b0, mx});
        check("stbi",  {31'b0, stbi},  {31'b0, ms});
        check("level", {29'b0, level}, 32'(q.size()));
        check("busy",  {31'b0, busy},  {31'b0, (q.size() != 0) || !idle});
        if (stbi === 1'b0) pulses.push_back(n);
        n++;
    endtask

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; hold = 1'b0;

        // Reset for 3 cycles, then idle
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 0, 1);
        for (int i = 0; i < 20; i++) cycle(0, 6'h00, 0, 0);

        // Single symbol
        cycle(1, 6'h05, 0, 0);
        for (int i = 0; i < 25; i++) cycle(0, 6'h00, 0, 0);

        // Five back-to-back pushes; commits must be SPACING+2 apart
        pulses.delete();
        for (int i = 0; i < 5; i++) cycle(1, 6'(6'h10 + i), 0, 0);
        for (int i = 0; i < 110; i++) cycle(0, 6'h00, 0, 0);
        check("pulse_count", 32'(pulses.size()), 32'd5);
        for (int i = 1; i < pulses.size(); i++)
            check("pulse_gap", 32'(pulses[i] - pulses[i-1]), 32'(SPACING + 2));

        // Fill under hold, then push in the pop cycle: refused, accepted next cycle
        for (int i = 0; i < 4; i++) cycle(1, 6'(6'h20 + i), 1, 0);
        for (int i = 0; i < 20; i++) cycle(0, 6'h00, 1, 0);
        cycle(1, 6'h2a, 0, 0);
        check("level_after_pop", {29'b0, level}, 32'd3);
        cycle(1, 6'h2a, 0, 0);
        check("level_refill", {29'b0, level}, 32'd4);
        for (int i = 0; i < 100; i++) cycle(0, 6'h00, 0, 0);

        // Hold with two queued symbols, then release
        cycle(1, 6'h31, 1, 0);
        cycle(1, 6'h32, 1, 0);
        for (int i = 0; i < 25; i++) cycle(0, 6'h00, 1, 0);
        for (int i = 0; i < 45; i++) cycle(0, 6'h00, 0, 0);

        // Reset during STROBE
        cycle(1, 6'h3c, 0, 0);
        for (int i = 0; i < 60 && stbi !== 1'b0; i++) cycle(0, 6'h00, 0, 0);
        check("strobe_seen", {31'b0, stbi}, 32'd0);
        cycle(1, 6'h3d, 0, 1);
        for (int i = 0; i < 25; i++) cycle(1, 6'(6'h01 + i), 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 2) != 0, 6'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 120; i++) cycle(0, 6'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
